// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin sharing of one external fixed-point multiplier among NUM_REQ
// requesters. Each accepted request runs IDLE -> EXEC -> RESP -> IDLE: the
// multiplier is enabled during EXEC, and its result is registered and returned
// to the owner as a one-cycle tagged pulse during RESP.
module mult_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [16*NUM_REQ-1:0] req_op_a,
   input  logic [16*NUM_REQ-1:0] req_op_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           rsp_data,
   output logic                  rsp_overflow,
   output logic                  ovf_sticky,
   input  logic                  ovf_clr,
   output logic                  busy,
   output logic                  mul_enable,
   output logic [15:0]           mul_op_a,
   output logic [15:0]           mul_op_b,
   input  logic [15:0]           mul_out,
   input  logic                  mul_overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      owner_q, owner_d;
   logic [15:0]          mul_op_a_q, mul_op_a_d;
   logic [15:0]          mul_op_b_q, mul_op_b_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
   logic [15:0]          rsp_data_q, rsp_data_d;
   logic                 rsp_overflow_q, rsp_overflow_d;
   logic                 ovf_sticky_q, ovf_sticky_d;

   logic [15:0]          op_a_arr [NUM_REQ];
   logic [15:0]          op_b_arr [NUM_REQ];
   logic                 win_found;
   logic [ID_W-1:0]      win_idx;

   // Unpack the flat operand buses into one 16-bit word per requester
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a_arr[gi] = req_op_a[16*gi +: 16];
      assign op_b_arr[gi] = req_op_b[16*gi +: 16];
   end

   // Round-robin search: first valid requester after the last one served
   always_comb begin
      int              cand;
      logic [ID_W-1:0] cand_idx;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand     = (int'(rr_ptr_q) + off) % NUM_REQ;
         cand_idx = ID_W'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Grant is combinational so the winner sees ready in the same IDLE cycle
   always_comb begin
      req_ready = '0;
      if (state_q == ST_IDLE && win_found) begin
         req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
      end
   end

   // Next-state and datapath capture for the three-phase operation
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      mul_op_a_d     = mul_op_a_q;
      mul_op_b_d     = mul_op_b_q;
      rsp_valid_d    = '0;
      rsp_id_d       = rsp_id_q;
      rsp_data_d     = rsp_data_q;
      rsp_overflow_d = rsp_overflow_q;
      ovf_sticky_d   = ovf_sticky_q;

      // Clear first so a same-edge overflow capture below takes precedence
      if (ovf_clr) begin
         ovf_sticky_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               mul_op_a_d = op_a_arr[win_idx];
               mul_op_b_d = op_b_arr[win_idx];
               owner_d    = win_idx;
               rr_ptr_d   = win_idx;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d     = mul_out;
            rsp_overflow_d = mul_overflow;
            rsp_id_d       = owner_q;
            rsp_valid_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            if (mul_overflow) begin
               ovf_sticky_d = 1'b1;
            end
            state_d        = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= ID_W'(NUM_REQ - 1);
         owner_q        <= '0;
         mul_op_a_q     <= '0;
         mul_op_b_q     <= '0;
         rsp_valid_q    <= '0;
         rsp_id_q       <= '0;
         rsp_data_q     <= '0;
         rsp_overflow_q <= 1'b0;
         ovf_sticky_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         owner_q        <= owner_d;
         mul_op_a_q     <= mul_op_a_d;
         mul_op_b_q     <= mul_op_b_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_data_q     <= rsp_data_d;
         rsp_overflow_q <= rsp_overflow_d;
         ovf_sticky_q   <= ovf_sticky_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign mul_enable   = (state_q == ST_EXEC);
   assign mul_op_a     = mul_op_a_q;
   assign mul_op_b     = mul_op_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_overflow = rsp_overflow_q;
   assign ovf_sticky   = ovf_sticky_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
// Directed bench for the shared-multiplier arbiter with a behavioural
// fixed-point multiplier (signed 13-bit mantissa product, scale bits zero).
`timescale 1ns/1ps
module tb_mult_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [16*NUM_REQ-1:0] req_op_a = '0;
   logic [16*NUM_REQ-1:0] req_op_b = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [ID_W-1:0]       rsp_id;
   logic [15:0]           rsp_data;
   logic                  rsp_overflow;
   logic                  ovf_sticky;
   logic                  ovf_clr = 1'b0;
   logic                  busy;
   logic                  mul_enable;
   logic [15:0]           mul_op_a;
   logic [15:0]           mul_op_b;
   logic [15:0]           mul_out;
   logic                  mul_overflow;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
      .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy),
      .mul_enable(mul_enable), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
      .mul_out(mul_out), .mul_overflow(mul_overflow)
   );

   // Behavioural multiplier: signed 13-bit x 13-bit, result must fit 13 bits
   logic signed [25:0] prod;
   always_comb begin
      prod         = $signed(mul_op_a[12:0]) * $signed(mul_op_b[12:0]);
      mul_out      = {3'b000, prod[12:0]};
      mul_overflow = (prod > 26'sd4095) || (prod < -26'sd4096);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
      req_op_a[16*i +: 16] = a;
      req_op_b[16*i +: 16] = b;
   endtask

   initial begin
      // Reset values with rst held from time zero
      #2;
      chk("rst_busy",      32'(busy), 32'h0);
      chk("rst_ready",     32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_mul_en",    32'(mul_enable), 32'h0);
      chk("rst_op_a",      32'(mul_op_a), 32'h0);
      chk("rst_sticky",    32'(ovf_sticky), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single op from requester 0
      req_valid = 4'b0001;
      set_ops(0, 16'h0010, 16'h0020);
      #1;
      chk("t2_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      chk("t2_exec_busy",  32'(busy), 32'h1);
      chk("t2_exec_en",    32'(mul_enable), 32'h1);
      chk("t2_exec_ready", 32'(req_ready), 32'h0);
      chk("t2_op_a",       32'(mul_op_a), 32'h0010);
      chk("t2_op_b",       32'(mul_op_b), 32'h0020);
      chk("t2_no_rsp_yet", 32'(rsp_valid), 32'h0);
      tick();
      chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t2_rsp_data",  32'(rsp_data), 32'h0200);
      chk("t2_rsp_id",    32'(rsp_id), 32'h0);
      chk("t2_rsp_ovf",   32'(rsp_overflow), 32'h0);
      chk("t2_resp_en",   32'(mul_enable), 32'h0);
      tick();
      chk("t2_rsp_drop", 32'(rsp_valid), 32'h0);
      chk("t2_idle",     32'(busy), 32'h0);
      chk("t2_hold",     32'(rsp_data), 32'h0200);

      // Asynchronous reset mid-cycle clears held outputs at once
      #3;
      rst = 1'b1;
      #1;
      chk("t1_rsp_data", 32'(rsp_data), 32'h0);
      chk("t1_busy",     32'(busy), 32'h0);
      chk("t1_ready",    32'(req_ready), 32'h0);
      chk("t1_op_a",     32'(mul_op_a), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Fairness: all four requesting, served 0,1,2,3 three cycles apart
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 16'(i + 1), 16'h0002);
      req_valid = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++) begin
         #1;
         chk($sformatf("t3_ready%0d", k), 32'(req_ready), 32'(1 << k));
         tick();
         chk($sformatf("t3_op_a%0d", k), 32'(mul_op_a), 32'(k + 1));
         tick();
         chk($sformatf("t3_rsp_valid%0d", k), 32'(rsp_valid), 32'(1 << k));
         chk($sformatf("t3_rsp_id%0d", k), 32'(rsp_id), 32'(k));
         chk($sformatf("t3_rsp_data%0d", k), 32'(rsp_data), 32'(2 * (k + 1)));
         tick();
      end
      req_valid = 4'b1010;
      for (int k = 1; k < NUM_REQ; k += 2) begin
         #1;
         chk($sformatf("t3b_ready%0d", k), 32'(req_ready), 32'(1 << k));
         tick();
         if (k == 3) req_valid = 4'b0000;
         tick();
         chk($sformatf("t3b_rsp_id%0d", k), 32'(rsp_id), 32'(k));
         tick();
      end

      // Overflow and sticky flag
      set_ops(0, 16'h0FFF, 16'h0FFF);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      tick();
      chk("t4_rsp_ovf", 32'(rsp_overflow), 32'h1);
      chk("t4_sticky",  32'(ovf_sticky), 32'h1);
      tick();
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      ovf_clr   = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t4_set_wins", 32'(ovf_sticky), 32'h1);
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t4_cleared", 32'(ovf_sticky), 32'h0);
      chk("t4_ovf_hold", 32'(rsp_overflow), 32'h1);

      // Reset while in EXEC abandons the op
      set_ops(1, 16'h0003, 16'h0003);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0000;
      chk("t5_busy_pre", 32'(busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_busy_rst", 32'(busy), 32'h0);
      chk("t5_en_rst",   32'(mul_enable), 32'h0);
      tick();
      chk("t5_no_rsp_a", 32'(rsp_valid), 32'h0);
      rst = 1'b0;
      tick();
      chk("t5_no_rsp_b", 32'(rsp_valid), 32'h0);
      set_ops(0, 16'h0004, 16'h0005);
      set_ops(2, 16'h0006, 16'h0007);
      req_valid = 4'b0101;
      #1;
      chk("t5_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0100;
      tick();
      chk("t5_rsp_data", 32'(rsp_data), 32'h0014);
      req_valid = 4'b0000;
      tick();
      chk("t5_idle", 32'(busy), 32'h0);

      // Withdrawal: requester 2 valid only during requester 1's EXEC
      set_ops(1, 16'h0008, 16'h0002);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0100;
      chk("t6_exec_ready", 32'(req_ready), 32'h0);
      tick();
      req_valid = 4'b0000;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t6_rsp_data",  32'(rsp_data), 32'h0010);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("t6_no_grant%0d", c), 32'({busy, req_ready[2], rsp_valid[2]}), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
